// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / instruction-fetch stage: widths, field positions,
// FSM state encoding and the control-flag bundle handed to the next-PC calculator.
package pc_fetch_unit_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned IMM_W      = 16;
  localparam int unsigned TARGET_W   = 26;
  localparam int unsigned WAIT_W     = 4;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0040_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  // Control-unit decisions plus the ALU zero flag, consumed only by the next-PC logic
  typedef struct packed {
    logic branch_eq;
    logic branch_ne;
    logic jump;
    logic jump_reg;
    logic zero;
  } ctrl_flags_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection: JR > J/JAL > taken branch > sequential.
// All additions wrap modulo 2^NBITS.
module pc_fetch_unit_next_pc_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned NBITS = PC_W
) (
  input  logic [NBITS-1:0]    pc,
  input  logic [TARGET_W-1:0] target_field,
  input  ctrl_flags_t         flags,
  input  logic [NBITS-3:0]    jr_word,
  output logic [NBITS-1:0]    next_pc_c
);

  logic [NBITS-1:0] pc_plus4;
  logic [NBITS-1:0] branch_off;
  logic [NBITS-1:0] branch_tgt;
  logic [NBITS-1:0] jump_tgt;
  logic [NBITS-1:0] jr_tgt;
  logic             taken;

  always_comb begin
    pc_plus4   = pc + NBITS'(4);
    branch_off = {{(NBITS-IMM_W-2){target_field[IMM_W-1]}}, target_field[IMM_W-1:0], 2'b00};
    branch_tgt = pc_plus4 + branch_off;
    jump_tgt   = {pc_plus4[NBITS-1:TARGET_W+2], target_field, 2'b00};
    // JR target low bits are dropped, so a misaligned rs still lands word-aligned
    jr_tgt     = {jr_word, 2'b00};
    taken      = (flags.branch_eq & flags.zero) | (flags.branch_ne & ~flags.zero);

    next_pc_c = pc_plus4;
    if (flags.jump_reg) begin
      next_pc_c = jr_tgt;
    end else if (flags.jump) begin
      next_pc_c = jump_tgt;
    end else if (taken) begin
      next_pc_c = branch_tgt;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: fetches over a req/ready handshake,
// holds the instruction for Control, and advances the PC once the consumer releases it.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned      NBITS    = PC_W,
  parameter logic [NBITS-1:0] RESET_PC = NBITS'(RESET_PC_DEF),
  parameter int unsigned      MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_o,
  output logic [NBITS-1:0]    imem_addr_o,
  input  logic                imem_ready_i,
  input  logic [INSTR_W-1:0]  imem_data_i,
  output logic [INSTR_W-1:0]  instr_o,
  output logic [OPCODE_W-1:0] opcode_o,
  output logic                instr_valid_o,
  output logic [NBITS-1:0]    pc_o,
  output logic [NBITS-1:0]    pc_plus4_o,
  input  logic                branch_eq_i,
  input  logic                branch_ne_i,
  input  logic                jump_i,
  input  logic                jump_reg_i,
  input  logic [NBITS-1:0]    jr_target_i,
  input  logic                zero_i,
  input  logic                stall_i,
  output logic                fetch_fault_o
);

  state_e              state_q, state_d;
  logic [NBITS-1:0]    pc_q, pc_d, pc4_q;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                fault_q, fault_d;
  logic                req_q, valid_q;
  logic [NBITS-1:0]    next_pc_c;
  ctrl_flags_t         flags;

  assign flags = '{branch_eq: branch_eq_i, branch_ne: branch_ne_i,
                   jump: jump_i, jump_reg: jump_reg_i, zero: zero_i};

  pc_fetch_unit_next_pc_calc #(.NBITS(NBITS)) u_next_pc (
    .pc           (pc_q),
    .target_field (ir_q[TARGET_W-1:0]),
    .flags        (flags),
    .jr_word      (jr_target_i[NBITS-1:2]),
    .next_pc_c    (next_pc_c)
  );

  // State register plus PC/IR/counter; req and valid are registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      pc4_q   <= RESET_PC + NBITS'(4);
      ir_q    <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc_d + NBITS'(4);
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      req_q   <= (state_d == S_FETCH);
      valid_q <= (state_d == S_EXEC);
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready_i) begin
          ir_d    = imem_data_i;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + WAIT_W'(1);
          // Give up once the counter reaches MAX_WAIT unanswered cycles
          if (cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (!stall_i) begin
          pc_d    = next_pc_c;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = ir_q;
  assign opcode_o      = ir_q[OPCODE_LSB +: OPCODE_W];
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc4_q;
  assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then random
// stimulus, all cross-checked every cycle against a transaction-level model.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic [5:0]  opcode_o;
  logic        instr_valid_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        branch_eq_i;
  logic        branch_ne_i;
  logic        jump_i;
  logic        jump_reg_i;
  logic [31:0] jr_target_i;
  logic        zero_i;
  logic        stall_i;
  logic        fetch_fault_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ready_i  (imem_ready_i),
    .imem_data_i   (imem_data_i),
    .instr_o       (instr_o),
    .opcode_o      (opcode_o),
    .instr_valid_o (instr_valid_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .branch_eq_i   (branch_eq_i),
    .branch_ne_i   (branch_ne_i),
    .jump_i        (jump_i),
    .jump_reg_i    (jump_reg_i),
    .jr_target_i   (jr_target_i),
    .zero_i        (zero_i),
    .stall_i       (stall_i),
    .fetch_fault_o (fetch_fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage is booting, waiting on imem, holding an instruction, or dead
  localparam int P_BOOT = 0, P_WAIT = 1, P_HOLD = 2, P_DEAD = 3;
  int          m_phase;
  int          m_unanswered;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic        m_fault;

  function automatic logic [31:0] model_next_pc();
    logic [31:0] p4;
    int          off;
    p4 = m_pc + 32'd4;
    if (jump_reg_i) return jr_target_i & 32'hFFFF_FFFC;
    if (jump_i) return (p4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
    if ((branch_eq_i && zero_i) || (branch_ne_i && !zero_i)) begin
      off = int'($signed(m_ir[15:0]));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = P_BOOT; m_unanswered = 0; m_pc = 32'h0040_0000; m_ir = 32'd0; m_fault = 1'b0;
    end else begin
      case (m_phase)
        P_BOOT: m_phase = P_WAIT;
        P_WAIT: begin
          if (imem_ready_i) begin
            m_ir = imem_data_i; m_unanswered = 0; m_phase = P_HOLD;
          end else begin
            m_unanswered++;
            if (m_unanswered >= 15) begin m_phase = P_DEAD; m_fault = 1'b1; end
          end
        end
        P_HOLD: if (!stall_i) begin m_pc = model_next_pc(); m_phase = P_WAIT; end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("req",      32'(imem_req_o),    32'(m_phase == P_WAIT));
      check("valid",    32'(instr_valid_o), 32'(m_phase == P_HOLD));
      check("addr",     imem_addr_o,        m_pc);
      check("pc",       pc_o,               m_pc);
      check("pc_plus4", pc_plus4_o,         m_pc + 32'd4);
      check("instr",    instr_o,            m_ir);
      check("opcode",   32'(opcode_o),      m_ir >> 26);
      check("fault",    32'(fetch_fault_o), 32'(m_fault));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic beq, bne, jmp, jr, z, input logic [31:0] jrt);
    branch_eq_i = beq; branch_ne_i = bne; jump_i = jmp; jump_reg_i = jr;
    zero_i = z; jr_target_i = jrt;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One fetch/execute: ready after ready_delay unanswered cycles, then stall_cyc held edges
  task automatic run_instr(input logic [31:0] word, input logic beq, bne, jmp, jr, z,
                           input logic [31:0] jrt, input int ready_delay, input int stall_cyc,
                           input logic [31:0] exp_pc, output int req_cycles);
    int n = 0;
    req_cycles = 0;
    imem_ready_i = 1'b0; imem_data_i = word; stall_i = 1'b0;
    set_ctrl(beq, bne, jmp, jr, z, jrt);
    while (!imem_req_o && n < 40) begin tick(); n++; end
    check("fetch_started", 32'(imem_req_o), 32'd1);
    for (int i = 0; i < ready_delay; i++) begin
      if (imem_req_o) req_cycles++;
      check("addr_stable", imem_addr_o, exp_pc);
      tick();
    end
    if (imem_req_o) req_cycles++;
    imem_ready_i = 1'b1;
    tick();
    imem_ready_i = 1'b0;
    stall_i = (stall_cyc > 0);
    for (int i = 0; i < stall_cyc; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid_o), 32'd1);
      check("stall_noreq", 32'(imem_req_o), 32'd0);
      check("stall_pc", pc_o, exp_pc);
    end
    stall_i = 1'b0;
    tick();
  endtask

  initial begin
    int rc;
    reset = 1'b0; imem_ready_i = 1'b0; imem_data_i = 32'd0; stall_i = 1'b0;
    set_ctrl(0, 0, 0, 0, 0, 32'd0);
    #3 reset = 1'b1;
    #1 chk_en = 1'b1;
    tick();
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_pc", pc_o, 32'h0040_0000);
    check("rst_instr", instr_o, 32'd0);

    // Zero-wait imem: one fetch every two cycles
    reset = 1'b0; imem_ready_i = 1'b1;
    tick();
    check("seq0_req", 32'(imem_req_o), 32'd1);
    check("seq0_addr", imem_addr_o, 32'h0040_0000);
    tick();
    check("seq0_valid", 32'(instr_valid_o), 32'd1);
    check("seq0_noreq", 32'(imem_req_o), 32'd0);
    tick();
    check("seq1_addr", imem_addr_o, 32'h0040_0004);
    check("seq1_req", 32'(imem_req_o), 32'd1);
    imem_ready_i = 1'b0;

    pulse_reset();
    run_instr({6'h02, 26'h010_0008}, 0, 0, 1, 0, 0, 32'd0, 0, 0, 32'h0040_0000, rc);
    check("j_target", imem_addr_o, 32'h0040_0020);
    run_instr(32'd0, 0, 0, 0, 1, 0, 32'h0040_0033, 0, 0, 32'h0040_0020, rc);
    check("jr_target", imem_addr_o, 32'h0040_0030);
    run_instr(32'd0, 0, 0, 0, 1, 0, 32'h0040_0010, 0, 0, 32'h0040_0030, rc);
    check("jr_to_10", imem_addr_o, 32'h0040_0010);
    run_instr(32'h1000_FFFF, 1, 0, 0, 0, 1, 32'd0, 0, 0, 32'h0040_0010, rc);
    check("beq_taken", imem_addr_o, 32'h0040_0010);
    run_instr(32'h1000_FFFF, 1, 0, 0, 0, 0, 32'd0, 0, 0, 32'h0040_0010, rc);
    check("beq_not_taken", imem_addr_o, 32'h0040_0014);
    run_instr(32'd0, 0, 0, 0, 0, 0, 32'd0, 3, 0, 32'h0040_0014, rc);
    check("ready_delay_req_cycles", 32'(rc), 32'd4);
    check("ready_delay_next", imem_addr_o, 32'h0040_0018);
    run_instr(32'd0, 0, 0, 0, 0, 0, 32'd0, 0, 5, 32'h0040_0018, rc);
    check("stall_next", imem_addr_o, 32'h0040_001C);
    run_instr(32'd0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0, 32'h0040_001C, rc);
    check("jr_top", imem_addr_o, 32'hFFFF_FFFC);
    run_instr(32'd0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 32'hFFFF_FFFC, rc);
    check("pc_wrap", imem_addr_o, 32'h0000_0000);

    // imem never answers: fault after 15 requesting cycles
    rc = 0;
    for (int i = 0; i < 40 && !fetch_fault_o; i++) begin
      if (imem_req_o) rc++;
      tick();
    end
    check("fault_req_cycles", 32'(rc), 32'd15);
    check("fault_set", 32'(fetch_fault_o), 32'd1);
    tick();
    check("fault_noreq", 32'(imem_req_o), 32'd0);

    // Async reset in the middle of a fetch
    pulse_reset();
    tick();
    check("pre_abort_req", 32'(imem_req_o), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_req", 32'(imem_req_o), 32'd0);
    check("abort_pc", pc_o, 32'h0040_0000);
    check("abort_fault", 32'(fetch_fault_o), 32'd0);
    tick();
    reset = 1'b0;

    // Random traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (fetch_fault_o || $urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        imem_ready_i = ($urandom_range(0, 3) != 0);
        imem_data_i  = $urandom;
        stall_i      = ($urandom_range(0, 3) == 0);
        set_ctrl(1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom), $urandom);
      end
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
